// File: rtl/traffic_pkg.sv
// Shared encodings for the traffic-light controller and its phase timer.
package traffic_pkg;

  localparam int unsigned ELAPSED_W     = 6;
  localparam int unsigned BCD_W         = 4;
  localparam int unsigned GREEN_SEC_DEF = 25;
  localparam int unsigned CYCLE_SEC_DEF = 30;

  typedef enum logic [1:0] {
    PH_INVALID = 2'd0,
    PH_GREEN1  = 2'd1,
    PH_GREEN2  = 2'd2,
    PH_YELLOW  = 2'd3
  } phase_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN_G = 2'd1,
    ST_RUN_Y = 2'd2,
    ST_FIRED = 2'd3
  } state_t;

  // Lamp outputs to phase; any lamp pattern not legal for a phase is INVALID.
  function automatic phase_t decode_phase(input logic lg1, input logic lg2,
                                          input logic ly1, input logic ly2);
    phase_t ph;
    ph = PH_INVALID;
    if (!ly1 && !ly2 && (lg1 ^ lg2)) begin
      ph = lg1 ? PH_GREEN1 : PH_GREEN2;
    end else if (ly1 && ly2 && !lg1 && !lg2) begin
      ph = PH_YELLOW;
    end
    return ph;
  endfunction

endpackage

// File: rtl/bin6_to_bcd.sv
// Combinational 6-bit binary to two BCD digits (tens 0-6, ones 0-9).
module bin6_to_bcd
  import traffic_pkg::*;
(
  input  logic [ELAPSED_W-1:0] bin,
  output logic [BCD_W-1:0]     tens_c,
  output logic [BCD_W-1:0]     ones_c
);

  always_comb begin
    tens_c = '0;
    for (int unsigned t = 1; t <= 6; t++) begin
      if (bin >= ELAPSED_W'(t * 10)) tens_c = BCD_W'(t);
    end
    ones_c = BCD_W'(bin - ELAPSED_W'(tens_c) * ELAPSED_W'(10));
  end

endmodule

// File: rtl/phase_timer.sv
// Phase timer: follows the lamp phase, counts 1 Hz ticks, pulses phase
// timeouts and drives the remaining seconds as two BCD digits.
module phase_timer
  import traffic_pkg::*;
#(
  parameter int unsigned GREEN_SEC = GREEN_SEC_DEF,
  parameter int unsigned CYCLE_SEC = CYCLE_SEC_DEF
) (
  input  logic             clk1,
  input  logic             rst_n,
  input  logic             tick_1hz,
  input  logic             LG1,
  input  logic             LG2,
  input  logic             LY1,
  input  logic             LY2,
  output logic             timeout25,
  output logic             timeout30,
  output logic [BCD_W-1:0] cnt_tens,
  output logic [BCD_W-1:0] cnt_ones
);

  state_t               state_q, state_d;
  phase_t               prev_q;
  phase_t               ph_c;
  logic [ELAPSED_W-1:0] elapsed_q, elapsed_d;
  logic [ELAPSED_W-1:0] elapsed_inc_c;
  logic [ELAPSED_W-1:0] disp_c;
  logic [BCD_W-1:0]     tens_c, ones_c;
  logic                 t25_d, t30_d;

  assign ph_c          = decode_phase(LG1, LG2, LY1, LY2);
  assign elapsed_inc_c = elapsed_q + ELAPSED_W'(1);

  always_ff @(posedge clk1) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      prev_q    <= PH_INVALID;
      elapsed_q <= '0;
      timeout25 <= 1'b0;
      timeout30 <= 1'b0;
      cnt_tens  <= '0;
      cnt_ones  <= '0;
    end else begin
      state_q   <= state_d;
      prev_q    <= ph_c;
      elapsed_q <= elapsed_d;
      timeout25 <= t25_d;
      timeout30 <= t30_d;
      cnt_tens  <= tens_c;
      cnt_ones  <= ones_c;
    end
  end

  // A phase change outranks a coincident tick: the counter reloads and the tick is dropped.
  always_comb begin
    state_d   = state_q;
    elapsed_d = elapsed_q;
    t25_d     = 1'b0;
    t30_d     = 1'b0;
    if (ph_c == PH_INVALID) begin
      state_d   = ST_IDLE;
      elapsed_d = '0;
    end else if (ph_c != prev_q) begin
      if (ph_c == PH_YELLOW) begin
        state_d   = ST_RUN_Y;
        elapsed_d = ELAPSED_W'(GREEN_SEC);
      end else begin
        state_d   = ST_RUN_G;
        elapsed_d = '0;
      end
    end else if (tick_1hz) begin
      case (state_q)
        ST_RUN_G: begin
          elapsed_d = elapsed_inc_c;
          if (elapsed_inc_c == ELAPSED_W'(GREEN_SEC)) begin
            state_d = ST_FIRED;
            t25_d   = 1'b1;
          end
        end
        ST_RUN_Y: begin
          elapsed_d = elapsed_inc_c;
          if (elapsed_inc_c == ELAPSED_W'(CYCLE_SEC)) begin
            state_d = ST_FIRED;
            t30_d   = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Remaining seconds of the running phase; zero once fired or idle.
  always_comb begin
    disp_c = '0;
    case (state_q)
      ST_RUN_G: disp_c = ELAPSED_W'(GREEN_SEC) - elapsed_q;
      ST_RUN_Y: disp_c = ELAPSED_W'(CYCLE_SEC) - elapsed_q;
      default:  disp_c = '0;
    endcase
  end

  bin6_to_bcd u_bcd (
    .bin    (disp_c),
    .tens_c (tens_c),
    .ones_c (ones_c)
  );

endmodule

// File: tb/tb_phase_timer.sv
// Directed bench for phase_timer, including a small closed-loop lamp controller model.
module tb_phase_timer;

  logic       clk1 = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick_1hz = 1'b0;
  logic       lg1 = 1'b0, lg2 = 1'b0, ly1 = 1'b0, ly2 = 1'b0;
  logic       timeout25, timeout30;
  logic [3:0] cnt_tens, cnt_ones;

  int total = 0;
  int bad   = 0;
  int tcount = 0, ph_ticks = 0;
  int p25 = 0, p30 = 0, last25 = 0, last30 = 0, ovl = 0;
  int ctl = 0;
  bit loop_en = 1'b0, pend = 1'b0;

  phase_timer dut (
    .clk1      (clk1),
    .rst_n     (rst_n),
    .tick_1hz  (tick_1hz),
    .LG1       (lg1),
    .LG2       (lg2),
    .LY1       (ly1),
    .LY2       (ly2),
    .timeout25 (timeout25),
    .timeout30 (timeout30),
    .cnt_tens  (cnt_tens),
    .cnt_ones  (cnt_ones)
  );

  always #5 clk1 = ~clk1;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int disp();
    return int'(cnt_tens) * 10 + int'(cnt_ones);
  endfunction

  task automatic set_lamps(input logic g1, input logic g2, input logic y1, input logic y2);
    lg1 = g1; lg2 = g2; ly1 = y1; ly2 = y2;
  endtask

  // Controller lamp pattern: NS_go, WaitA, EW_go, WaitB.
  task automatic apply_ctl();
    case (ctl)
      0:       set_lamps(1'b1, 1'b0, 1'b0, 1'b0);
      2:       set_lamps(1'b0, 1'b1, 1'b0, 1'b0);
      default: set_lamps(1'b0, 1'b0, 1'b1, 1'b1);
    endcase
  endtask

  task automatic observe();
    if (pend) begin
      apply_ctl();
      ph_ticks = 0;
      pend = 1'b0;
    end
    if (timeout25 && timeout30) ovl++;
    if (timeout25) begin
      p25++;
      last25 = tcount;
      if (loop_en) begin
        chk("loop_green_ticks", ph_ticks, 25);
        chk("loop_green_phase", ctl % 2, 0);
        ctl = (ctl + 1) % 4;
        pend = 1'b1;
      end
    end
    if (timeout30) begin
      p30++;
      last30 = tcount;
      if (loop_en) begin
        chk("loop_yellow_ticks", ph_ticks, 5);
        chk("loop_yellow_phase", ctl % 2, 1);
        ctl = (ctl + 1) % 4;
        pend = 1'b1;
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk1);
    #1;
    observe();
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic run(input int n, input int period);
    for (int i = 0; i < n; i++) begin
      tick_1hz = 1'b1;
      tcount++;
      ph_ticks++;
      cyc();
      tick_1hz = 1'b0;
      for (int j = 1; j < period; j++) cyc();
    end
  endtask

  initial begin
    // Reset with green already on the lamps
    set_lamps(1'b0, 1'b1, 1'b0, 1'b0);
    rst_n = 1'b0;
    cycles(3);
    chk("rst_t25", int'(timeout25), 0);
    chk("rst_t30", int'(timeout30), 0);
    chk("rst_tens", int'(cnt_tens), 0);
    chk("rst_ones", int'(cnt_ones), 0);

    rst_n = 1'b1;
    tcount = 0;
    cycles(2);
    chk("green_entry_disp", disp(), 25);
    chk("green_entry_tens", int'(cnt_tens), 2);
    run(1, 4);
    chk("green_first_tick", disp(), 24);

    // Green expiry on the 25th tick, then no further pulses
    p25 = 0; p30 = 0;
    run(24, 4);
    chk("green_pulses", p25, 1);
    chk("green_pulse_tick", last25, 25);
    chk("fired_disp", disp(), 0);
    run(10, 4);
    chk("fired_no_repeat", p25, 1);
    chk("fired_no_t30", p30, 0);

    // Yellow expiry on the 5th tick
    set_lamps(1'b0, 1'b0, 1'b1, 1'b1);
    cycles(2);
    chk("yellow_entry_disp", disp(), 5);
    tcount = 0; p25 = 0; p30 = 0;
    run(5, 4);
    chk("yellow_pulses", p30, 1);
    chk("yellow_pulse_tick", last30, 5);
    chk("yellow_no_t25", p25, 0);
    chk("yellow_end_disp", disp(), 0);

    // Lamp change coincident with a tick: tick is discarded
    set_lamps(1'b1, 1'b0, 1'b0, 1'b0);
    cycles(3);
    run(3, 4);
    chk("green1_disp", disp(), 22);
    set_lamps(1'b0, 1'b0, 1'b1, 1'b1);
    tick_1hz = 1'b1;
    cyc();
    tick_1hz = 1'b0;
    cycles(2);
    chk("simul_disp", disp(), 5);
    run(1, 4);
    chk("simul_next_tick", disp(), 4);

    // Invalid lamps mid-green
    set_lamps(1'b1, 1'b0, 1'b0, 1'b0);
    cycles(2);
    run(5, 4);
    chk("green_mid_disp", disp(), 20);
    set_lamps(1'b0, 1'b0, 1'b0, 1'b0);
    p25 = 0; p30 = 0;
    cycles(2);
    chk("idle_tens", int'(cnt_tens), 0);
    chk("idle_ones", int'(cnt_ones), 0);
    run(30, 4);
    chk("idle_no_t25", p25, 0);
    chk("idle_no_t30", p30, 0);
    chk("idle_disp", disp(), 0);
    set_lamps(1'b1, 1'b0, 1'b0, 1'b0);
    cycles(2);
    chk("from_idle_disp", disp(), 25);

    // Reset at elapsed=12 restarts the green count
    run(12, 4);
    chk("pre_reset_disp", disp(), 13);
    rst_n = 1'b0;
    cyc();
    chk("mid_reset_disp", disp(), 0);
    rst_n = 1'b1;
    cycles(2);
    chk("post_reset_disp", disp(), 25);
    run(1, 4);
    chk("post_reset_tick", disp(), 24);

    // Closed loop: three full controller cycles
    set_lamps(1'b0, 1'b0, 1'b0, 1'b0);
    cycles(2);
    ctl = 0;
    apply_ctl();
    ph_ticks = 0;
    p25 = 0; p30 = 0; ovl = 0;
    loop_en = 1'b1;
    cycles(2);
    run(180, 4);
    cycles(4);
    loop_en = 1'b0;
    chk("loop_t25_count", p25, 6);
    chk("loop_t30_count", p30, 6);
    chk("loop_overlap", ovl, 0);
    chk("loop_end_state", ctl, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/phase_timer.md
# phase_timer

Timing source for the two-way traffic-light controller. It watches the controller's lamp outputs and counts seconds on a 1 Hz enable. It pulses `timeout25` at the end of the green phase and `timeout30` at the end of the yellow phase. It also drives the remaining seconds of the current phase as two BCD digits for the countdown display enabled by `eLED01`/`eLED23`.

## Interface
Parameters:
- `GREEN_SEC`, default 25: seconds from green entry to `timeout25`.
- `CYCLE_SEC`, default 30: seconds from green entry to `timeout30`. Legal range: `GREEN_SEC < CYCLE_SEC ≤ 63`.

Ports:
- `clk1`  in  1  system clock. Same clock as the light controller.
- `rst_n`  in  1  reset. One clock; reset is synchronous and active-low.
- `tick_1hz`  in  1  one-`clk1`-cycle enable, once per second.
- `LG1`, `LG2`, `LY1`, `LY2`  in  1 each  lamp outputs of the light controller.
- `timeout25`  out  1  one-cycle pulse: green time expired.
- `timeout30`  out  1  one-cycle pulse: yellow time expired.
- `cnt_tens`  out  4  BCD tens digit of remaining seconds.
- `cnt_ones`  out  4  BCD ones digit of remaining seconds.

## Operation
- Phase decode, combinational on the lamp inputs:
  - GREEN = exactly one of `LG1`/`LG2` high and both yellows low.
  - YELLOW = `LY1 & LY2` and both greens low.
  - Any other combination = INVALID.
- FSM states:
  - IDLE: no valid phase.
  - RUN_G: counting green.
  - RUN_Y: counting yellow.
  - FIRED: timeout issued, waiting for the phase to change.
- `elapsed`: 6-bit seconds counter. It increments on `tick_1hz` in RUN_G and RUN_Y only and never exceeds `CYCLE_SEC`.
- Phase-change detection compares the decoded phase with a registered copy of the previous phase. A change from `LG1` to `LG2` (or back) counts as a new green.
- Transitions:
  - Any state, new GREEN detected → RUN_G, `elapsed`=0.
  - Any state, new YELLOW detected → RUN_Y, `elapsed`=`GREEN_SEC`.
  - Any state, INVALID → IDLE, `elapsed`=0.
  - RUN_G, tick with `elapsed`+1 == `GREEN_SEC` → FIRED; `timeout25`=1 next cycle.
  - RUN_Y, tick with `elapsed`+1 == `CYCLE_SEC` → FIRED; `timeout30`=1 next cycle.
  - FIRED: holds until a phase change. It issues no further pulses and ignores ticks.
- Display value:
  - RUN_G: `GREEN_SEC − elapsed`.
  - RUN_Y: `CYCLE_SEC − elapsed`.
  - FIRED and IDLE: 0.
  - The value is converted to BCD (0–63), so `cnt_tens` never exceeds 6.
- A phase change in the same cycle as `tick_1hz` wins: the counter reloads and the tick is discarded.
- `timeout25` and `timeout30` are never high together.

## Timing
- Reset (`rst_n`=0 at a `clk1` edge) loads:
  - state IDLE
  - `elapsed`=0
  - previous phase = INVALID
  - `timeout25`=0, `timeout30`=0
  - `cnt_tens`=0, `cnt_ones`=0
- Reset asserted mid-phase aborts the count. After release, a valid lamp phase is treated as new, so counting restarts from phase entry.
- Timeout latency: pulse is high exactly one `clk1` cycle, the cycle after the qualifying tick edge. The controller samples it on the following edge, and the lamps change one cycle later.
- Phase-change latency: a lamp change at edge N loads the counter at edge N+1.
- Display latency: the BCD digits are registered and follow `elapsed` by one cycle.
- With default parameters, in steady state green spans 25 ticks and yellow spans 5 ticks. Slack of 2–3 `clk1` cycles per phase comes from the handshake, independent of tick rate.

## Structure
- Shared package `traffic_pkg` holds:
  - phase encoding constants PH_INVALID, PH_GREEN1, PH_GREEN2, PH_YELLOW (2 bits, distinct)
  - FSM state encoding
  - default durations 25 and 30
- The package is also used by the light controller for the lamp-state encoding.
- Sub-module `bin6_to_bcd`: combinational 6-bit binary to two BCD nibbles (tens 0–6, ones 0–9). It is instantiated once.
- Main module: phase decode, FSM, counter, output registers.

## Test plan
- Reset: hold `rst_n`=0 for 3 cycles with `LG2`=1 → all outputs 0. After release, state RUN_G with display reading 25, then 24 after the first tick.
- Green expiry: `LG2`=1, `tick_1hz` every 4 cycles → exactly one `timeout25` pulse, on the cycle after the 25th tick. Display reads 0 afterwards, and 10 further ticks give no second pulse.
- Yellow expiry: after the green pulse, drive `LY1`=`LY2`=1 → display reads 5. `timeout30` pulses once, the cycle after the 5th tick.
- Closed loop with the light controller: 3 full cycles → pattern NS_go(25 s), WaitA(5 s), EW_go(25 s), WaitB(5 s). Timeouts never overlap.
- Simultaneous event: lamp change to yellow in the same cycle as a tick → `elapsed`=25 and display 5; the tick is not counted.
- Invalid lamps and mid-run reset: all lamps 0 mid-green → IDLE, display 0, no pulses. Separately, `rst_n` low at `elapsed`=12 → count restarts at 25 after release.
